// File: rtl/cloud_bist_pkg.sv
// Shared types and the x^8+x^6+x^5+x^4+1 feedback helper for the cloud datapath BIST.
package cloud_bist_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRstd,
        StApply,
        StDrain,
        StDone
    } bist_state_e;

    localparam logic [7:0] LfsrTaps = 8'hB8;

    function automatic logic [7:0] lfsr8_next(logic [7:0] l);
        return {l[6:0], ^(l & LfsrTaps)};
    endfunction

endpackage

// File: rtl/bist_lfsr8.sv
// 8-bit Fibonacci shift register; with xor_i tied low it is a pattern LFSR, otherwise a MISR.
module bist_lfsr8
    import cloud_bist_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       en_i,
    input  logic [7:0] xor_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (en_i) begin
            state_d = lfsr8_next(state_q) ^ xor_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/cloud_bist_ctrl.sv
// BIST sequencer: resets the datapath, applies LFSR vectors, folds the responses into a MISR
// and reports the signature with a golden compare.
module cloud_bist_ctrl
    import cloud_bist_pkg::*;
#(
    parameter int unsigned LAT       = 1,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter logic [7:0]  MISR_SEED = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_patterns,
    input  logic [7:0]  expected_sig,
    output logic        dut_rst,
    output logic [7:0]  dut_in,
    input  logic [7:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic [7:0]  signature,
    output logic        pass,
    output logic        aborted
);

    bist_state_e    state_q;
    logic [15:0]    cnt_q;
    logic [LAT-1:0] tok_q, tok_shift;
    logic           dut_rst_q, busy_q, done_q, pass_q, aborted_q;
    logic [7:0]     dut_in_q, sig_q, lfsr_q, misr_q, misr_next;
    logic           start_ok, abort_ok, cnt_zero, lfsr_en, capture, tok_in, to_done;

    assign start_ok = (state_q == StIdle) && start;
    assign abort_ok = abort && ((state_q == StRstd) || (state_q == StApply) ||
                                (state_q == StDrain));
    assign cnt_zero = (cnt_q == 16'd0);
    assign lfsr_en  = !abort_ok && !cnt_zero && ((state_q == StRstd) || (state_q == StApply));
    assign tok_in   = (state_q == StApply) && !abort_ok;
    assign capture  = tok_q[LAT-1];

    // Signature and compare must see the capture happening on the same edge that enters DONE.
    assign misr_next = capture ? (lfsr8_next(misr_q) ^ dut_out) : misr_q;

    always_comb begin
        tok_shift    = '0;
        tok_shift[0] = tok_in;
        for (int i = 1; i < int'(LAT); i++) begin
            tok_shift[i] = tok_q[i-1];
        end
    end

    assign to_done = abort_ok || ((state_q == StRstd) && cnt_zero) ||
                     ((state_q == StDrain) && (tok_shift == '0));

    bist_lfsr8 #(.RST_VAL(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start_ok),
        .seed_i  (LFSR_SEED),
        .en_i    (lfsr_en),
        .xor_i   (8'h00),
        .state_o (lfsr_q)
    );

    bist_lfsr8 #(.RST_VAL(MISR_SEED)) u_misr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start_ok),
        .seed_i  (MISR_SEED),
        .en_i    (capture),
        .xor_i   (dut_out),
        .state_o (misr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            tok_q     <= '0;
            dut_rst_q <= 1'b0;
            dut_in_q  <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sig_q     <= MISR_SEED;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            dut_rst_q <= 1'b0;
            dut_in_q  <= 8'h00;
            done_q    <= 1'b0;
            tok_q     <= abort_ok ? '0 : tok_shift;
            if (lfsr_en) begin
                dut_in_q <= lfsr_q;
                cnt_q    <= cnt_q - 16'd1;
            end
            if (to_done) begin
                state_q   <= StDone;
                done_q    <= 1'b1;
                sig_q     <= misr_next;
                pass_q    <= !abort_ok && (misr_next == expected_sig);
                aborted_q <= abort_ok;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q   <= StRstd;
                            cnt_q     <= num_patterns;
                            dut_rst_q <= 1'b1;
                            busy_q    <= 1'b1;
                            pass_q    <= 1'b0;
                            aborted_q <= 1'b0;
                        end
                    end
                    StRstd:  state_q <= StApply;
                    StApply: if (cnt_zero) state_q <= StDrain;
                    StDrain: state_q <= StDrain;
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign dut_rst   = dut_rst_q;
    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign pass      = pass_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_cloud_bist_ctrl.sv
// Directed bench for cloud_bist_ctrl against loopback datapath models at LAT=1 and LAT=4.
module tb_cloud_bist_ctrl;

    typedef struct {
        logic [7:0] sig;
        logic       pass;
        logic       aborted;
        bit         chk_sig;
        int         done_cyc;
    } exp_t;

    logic        clk, rst, start, abort, start4;
    logic [15:0] num_patterns;
    logic [7:0]  expected_sig;
    logic        dut_rst1, busy1, done1, pass1, aborted1;
    logic [7:0]  dut_in1, dut_out1, sig1;
    logic        dut_rst4, busy4, done4, pass4, aborted4;
    logic [7:0]  dut_in4, dut_out4, sig4;
    logic [7:0]  lb4 [4];

    logic [7:0] vec_q [$];
    exp_t       res_q [$];
    int         n_tests, n_fail;

    cloud_bist_ctrl #(.LAT(1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .num_patterns (num_patterns),
        .expected_sig (expected_sig),
        .dut_rst      (dut_rst1),
        .dut_in       (dut_in1),
        .dut_out      (dut_out1),
        .busy         (busy1),
        .done         (done1),
        .signature    (sig1),
        .pass         (pass1),
        .aborted      (aborted1)
    );

    cloud_bist_ctrl #(.LAT(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start4),
        .abort        (1'b0),
        .num_patterns (num_patterns),
        .expected_sig (expected_sig),
        .dut_rst      (dut_rst4),
        .dut_in       (dut_in4),
        .dut_out      (dut_out4),
        .busy         (busy4),
        .done         (done4),
        .signature    (sig4),
        .pass         (pass4),
        .aborted      (aborted4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback datapaths: response equals the vector, LAT cycles later.
    always @(posedge clk) begin
        dut_out1 <= dut_in1;
        lb4[0]   <= dut_in4;
        for (int i = 1; i < 4; i++) lb4[i] <= lb4[i-1];
    end
    assign dut_out4 = lb4[3];

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int n, input logic [7:0] golden, input int abort_cyc,
                          input bit want_done);
        logic [7:0] l, m;
        int         nvec;
        exp_t       e;
        l    = 8'hA5;
        m    = 8'h00;
        nvec = (abort_cyc > 0 && abort_cyc - 1 < n) ? abort_cyc - 1 : n;
        for (int k = 0; k < n; k++) begin
            if (k < nvec) vec_q.push_back(l);
            m = lfsr_step(m) ^ l;
            l = lfsr_step(l);
        end
        e.sig      = m;
        e.pass     = (abort_cyc > 0) ? 1'b0 : (m == golden);
        e.aborted  = (abort_cyc > 0);
        e.chk_sig  = (abort_cyc == 0);
        e.done_cyc = (abort_cyc > 0) ? abort_cyc + 1 : ((n == 0) ? 2 : n + 3);
        if (want_done) res_q.push_back(e);
        num_patterns = n[15:0];
        expected_sig = golden;
        start        = 1'b1;
    endtask

    task automatic watch(input string tag, input int abort_cyc, input int restart_cyc,
                         input int rst_cyc);
        int         last_vec, limit;
        bit         seen;
        exp_t       e;
        logic [7:0] exp_in;
        last_vec = vec_q.size() + 1;
        seen     = 0;
        limit    = (rst_cyc > 0) ? rst_cyc + 3 : res_q[0].done_cyc + 3;
        for (int c = 1; c <= limit && !seen; c++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (rst_cyc > 0 && c > rst_cyc) begin
                chk({tag, " no_done"}, done1, 0);
                if (c == rst_cyc + 1) begin
                    chk({tag, " rst busy"}, busy1, 0);
                    chk({tag, " rst dut_rst"}, dut_rst1, 0);
                    chk({tag, " rst dut_in"}, dut_in1, 0);
                    chk({tag, " rst sig"}, sig1, 8'h00);
                    chk({tag, " rst pass"}, pass1, 0);
                    chk({tag, " rst aborted"}, aborted1, 0);
                end
            end else begin
                if (c == 1) begin
                    chk({tag, " aborted cleared"}, aborted1, 0);
                    chk({tag, " pass cleared"}, pass1, 0);
                end
                chk({tag, " dut_rst"}, dut_rst1, (c == 1) ? 1 : 0);
                exp_in = 8'h00;
                if (c >= 2 && c <= last_vec) exp_in = vec_q.pop_front();
                chk({tag, " dut_in"}, dut_in1, exp_in);
                if (done1 === 1'b1) begin
                    seen = 1;
                    e    = res_q.pop_front();
                    chk({tag, " done cycle"}, c, e.done_cyc);
                    if (e.chk_sig) chk({tag, " signature"}, sig1, e.sig);
                    chk({tag, " pass"}, pass1, e.pass);
                    chk({tag, " aborted"}, aborted1, e.aborted);
                end else begin
                    chk({tag, " busy"}, busy1, 1);
                end
            end
            if (c == abort_cyc) abort = 1'b1;
            if (c == restart_cyc) begin
                start        = 1'b1;
                num_patterns = 16'd7;
            end
            if (c == rst_cyc) rst = 1'b1;
        end
        if (rst_cyc == 0) chk({tag, " done seen"}, seen, 1);
        tick();
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        chk({tag, " done one-shot"}, done1, 0);
        chk({tag, " idle busy"}, busy1, 0);
    endtask

    initial begin
        int done_cyc4;
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        start4       = 1'b0;
        abort        = 1'b0;
        num_patterns = 16'd0;
        expected_sig = 8'h00;
        repeat (3) tick();
        chk("reset busy", busy1, 0);
        chk("reset done", done1, 0);
        chk("reset dut_rst", dut_rst1, 0);
        chk("reset dut_in", dut_in1, 0);
        chk("reset signature", sig1, 8'h00);
        chk("reset pass", pass1, 0);
        chk("reset aborted", aborted1, 0);
        chk("reset busy4", busy4, 0);
        rst = 1'b0;
        tick();

        launch(3, 8'h95, 0, 1);
        watch("seq3", 0, 0, 0);
        chk("seq3 golden sig", sig1, 8'h95);
        chk("seq3 pass held", pass1, 1);

        launch(2, 8'h00, 0, 1);
        watch("n2 match", 0, 0, 0);
        chk("n2 golden sig", sig1, 8'h00);
        launch(2, 8'h01, 0, 1);
        watch("n2 mismatch", 0, 0, 0);

        launch(0, 8'h00, 0, 1);
        watch("n0", 0, 0, 0);
        chk("n0 golden sig", sig1, 8'h00);

        launch(100, 8'h00, 6, 1);
        watch("abort", 6, 0, 0);
        chk("abort aborted held", aborted1, 1);
        launch(1, 8'hA5, 0, 1);
        watch("after abort", 0, 0, 0);

        launch(3, 8'h95, 0, 1);
        watch("restart ignored", 0, 3, 0);

        launch(3, 8'h95, 0, 0);
        watch("mid rst", 0, 0, 5);

        num_patterns = 16'd1;
        expected_sig = 8'hA5;
        start4       = 1'b1;
        done_cyc4    = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start4 = 1'b0;
            if (c == 1) chk("lat4 dut_rst", dut_rst4, 1);
            if (c == 2) chk("lat4 vec0", dut_in4, 8'hA5);
            if (c == 3) chk("lat4 drain dut_in", dut_in4, 8'h00);
            if (done4 === 1'b1 && done_cyc4 < 0) done_cyc4 = c;
        end
        chk("lat4 done cycle", done_cyc4, 7);
        chk("lat4 signature", sig4, 8'hA5);
        chk("lat4 pass", pass4, 1);
        chk("lat4 aborted", aborted4, 0);
        chk("lat4 idle busy", busy4, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
